// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - decode-side and execute-side handshakes of the register-read stage
interface operand_fetch_if #(
    parameter int XLEN = 32,
    parameter int UOPW = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [4:0]      in_rd;
    logic            in_rd_en;
    logic [UOPW-1:0] in_uop;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_rs1val;
    logic [XLEN-1:0] out_rs2val;
    logic [4:0]      out_rd;
    logic            out_rd_en;
    logic [UOPW-1:0] out_uop;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_en, in_uop,
        output in_ready,
        output out_valid, out_rs1val, out_rs2val, out_rd, out_rd_en, out_uop,
        input  out_ready
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_en, in_uop,
        input  in_ready,
        input  out_valid, out_rs1val, out_rs2val, out_rd, out_rd_en, out_uop,
        output out_ready
    );
endinterface

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register-read stage: operand bypass, scoreboard hazard stall, registered output
module operand_fetch #(
    parameter int XLEN = 32,
    parameter int UOPW = 64
) (
    input  logic            clk,
    input  logic            rst,
    operand_fetch_if.slave  fe,
    output logic [4:0]      rf_r0addr,
    output logic [4:0]      rf_r1addr,
    input  logic [XLEN-1:0] rf_r0val,
    input  logic [XLEN-1:0] rf_r1val,
    output logic            rf_w0en,
    output logic [4:0]      rf_w0addr,
    output logic [XLEN-1:0] rf_w0val,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_val
);
    logic [31:0]     wb_clr;
    logic [31:0]     busy_live;
    logic [31:0]     busy_q, busy_d;
    logic            src_stall, dst_stall, free, in_ready, accept;
    logic [XLEN-1:0] rs1_res, rs2_res;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] rs1val_q, rs1val_d;
    logic [XLEN-1:0] rs2val_q, rs2val_d;
    logic [4:0]      rd_q, rd_d;
    logic            rd_en_q, rd_en_d;
    logic [UOPW-1:0] uop_q, uop_d;

    // The register file only sees a write at the next edge, so a same-cycle writeback is bypassed here.
    function automatic logic [XLEN-1:0] resolve(input logic [4:0] rs, input logic [XLEN-1:0] rf_val,
                                                input logic byp_en, input logic [4:0] byp_addr,
                                                input logic [XLEN-1:0] byp_val);
        resolve = (rs == 5'd0) ? '0 : ((byp_en && byp_addr == rs) ? byp_val : rf_val);
    endfunction

    assign rf_w0en   = wb_en && (wb_addr != 5'd0);
    assign rf_w0addr = wb_addr;
    assign rf_w0val  = wb_val;
    assign rf_r0addr = fe.in_rs1;
    assign rf_r1addr = fe.in_rs2;

    assign rs1_res = resolve(fe.in_rs1, rf_r0val, wb_en, wb_addr, wb_val);
    assign rs2_res = resolve(fe.in_rs2, rf_r1val, wb_en, wb_addr, wb_val);

    always_comb begin
        wb_clr = '0;
        if (wb_en) begin
            wb_clr[wb_addr] = 1'b1;
        end
        // Hazards see the scoreboard after this cycle's writeback, so a consumer issues in the wb cycle.
        busy_live = busy_q & ~wb_clr;
        src_stall = busy_live[fe.in_rs1] | busy_live[fe.in_rs2];
        dst_stall = fe.in_rd_en & busy_live[fe.in_rd];
        free      = !out_valid_q || fe.out_ready;
        in_ready  = free && !src_stall && !dst_stall;
        accept    = fe.in_valid && in_ready;

        busy_d = busy_live;
        if (accept && fe.in_rd_en && fe.in_rd != 5'd0) begin
            busy_d[fe.in_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        rs1val_d    = rs1val_q;
        rs2val_d    = rs2val_q;
        rd_d        = rd_q;
        rd_en_d     = rd_en_q;
        uop_d       = uop_q;
        if (accept) begin
            out_valid_d = 1'b1;
            rs1val_d    = rs1_res;
            rs2val_d    = rs2_res;
            rd_d        = fe.in_rd;
            rd_en_d     = fe.in_rd_en;
            uop_d       = fe.in_uop;
        end else if (fe.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            rs1val_q    <= '0;
            rs2val_q    <= '0;
            rd_q        <= '0;
            rd_en_q     <= 1'b0;
            uop_q       <= '0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            rs1val_q    <= rs1val_d;
            rs2val_q    <= rs2val_d;
            rd_q        <= rd_d;
            rd_en_q     <= rd_en_d;
            uop_q       <= uop_d;
        end
    end

    assign fe.in_ready   = in_ready;
    assign fe.out_valid  = out_valid_q;
    assign fe.out_rs1val = rs1val_q;
    assign fe.out_rs2val = rs2val_q;
    assign fe.out_rd     = rd_q;
    assign fe.out_rd_en  = rd_en_q;
    assign fe.out_uop    = uop_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - self-checking bench for operand_fetch against a register/scoreboard reference model
module tb_operand_fetch;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    operand_fetch_if #(.XLEN(32), .UOPW(64)) ifc();

    logic [4:0]  rf_r0addr, rf_r1addr, rf_w0addr, wb_addr;
    logic [31:0] rf_r0val, rf_r1val, rf_w0val, wb_val;
    logic        rf_w0en, wb_en;
    logic [31:0] rf_mem [32];

    assign rf_r0val = rf_mem[rf_r0addr];
    assign rf_r1val = rf_mem[rf_r1addr];

    operand_fetch #(.XLEN(32), .UOPW(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .fe        (ifc),
        .rf_r0addr (rf_r0addr),
        .rf_r1addr (rf_r1addr),
        .rf_r0val  (rf_r0val),
        .rf_r1val  (rf_r1val),
        .rf_w0en   (rf_w0en),
        .rf_w0addr (rf_w0addr),
        .rf_w0val  (rf_w0val),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_val    (wb_val)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural registers, pending-write flags, and the contents of the output slot.
    bit          m_busy [32];
    logic [31:0] m_regs [32];
    bit          m_ov;
    logic [31:0] m_rs1v, m_rs2v;
    logic [4:0]  m_rd;
    bit          m_rd_en;
    logic [63:0] m_uop;
    bit          m_acc;

    function automatic logic [31:0] m_resolve(input logic [4:0] rs);
        if (rs == 5'd0) return 32'd0;
        if (wb_en && wb_addr == rs) return wb_val;
        return m_regs[rs];
    endfunction

    function automatic bit m_pending(input logic [4:0] r);
        return (r != 5'd0) && m_busy[r] && !(wb_en && wb_addr == r);
    endfunction

    function automatic bit m_ready();
        return (!m_ov || ifc.out_ready) && !m_pending(ifc.in_rs1) && !m_pending(ifc.in_rs2)
               && !(ifc.in_rd_en && m_pending(ifc.in_rd));
    endfunction

    task automatic model_reset();
        m_ov = 0; m_rs1v = 0; m_rs2v = 0; m_rd = 0; m_rd_en = 0; m_uop = 0;
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
    endtask

    task automatic step();
        bit          w_en;
        logic [4:0]  w_addr;
        logic [31:0] w_val;
        w_en = rf_w0en; w_addr = rf_w0addr; w_val = rf_w0val;
        if (rst) begin
            m_acc = ifc.in_valid && m_ready();
            if (m_acc) begin
                m_ov = 1;
                m_rs1v = m_resolve(ifc.in_rs1);
                m_rs2v = m_resolve(ifc.in_rs2);
                m_rd = ifc.in_rd; m_rd_en = ifc.in_rd_en; m_uop = ifc.in_uop;
            end else if (ifc.out_ready) begin
                m_ov = 0;
            end
            if (wb_en) m_busy[wb_addr] = 0;
            if (m_acc && ifc.in_rd_en && ifc.in_rd != 5'd0) m_busy[ifc.in_rd] = 1;
            if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_val;
        end
        @(posedge clk);
        if (w_en) rf_mem[w_addr] = w_val;
        #1;
    endtask

    task automatic idle();
        ifc.in_valid = 0; ifc.in_rs1 = 0; ifc.in_rs2 = 0; ifc.in_rd = 0; ifc.in_rd_en = 0;
        ifc.in_uop = 0; ifc.out_ready = 1; wb_en = 0; wb_addr = 0; wb_val = 0;
    endtask

    task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input bit rd_en);
        ifc.in_valid = 1; ifc.in_rs1 = rs1; ifc.in_rs2 = rs2; ifc.in_rd = rd; ifc.in_rd_en = rd_en;
        ifc.in_uop = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        idle();
        rst = 0;
        model_reset();
        #1;
        n_checks++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", ifc.out_valid); end
        n_checks++; if (ifc.out_rs1val !== 32'd0 || ifc.out_rs2val !== 32'd0) begin n_fail++; $display("FAIL reset_operands: got %h/%h want 0/0", ifc.out_rs1val, ifc.out_rs2val); end
        n_checks++; if (ifc.out_uop !== 64'd0 || ifc.out_rd !== 5'd0 || ifc.out_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_payload: got uop=%h rd=%0d en=%0b want 0", ifc.out_uop, ifc.out_rd, ifc.out_rd_en); end
        step();
        rst = 1;
        #1;
        n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", ifc.in_ready); end
    endtask

    task automatic test_wb_then_read();
        wb_en = 1; wb_addr = 5; wb_val = 32'h1234;
        #1;
        n_checks++; if (rf_w0en !== 1'b1 || rf_w0addr !== 5'd5 || rf_w0val !== 32'h1234) begin n_fail++; $display("FAIL wb_port: got en=%0b addr=%0d val=%h want 1/5/1234", rf_w0en, rf_w0addr, rf_w0val); end
        step();
        wb_en = 0;
        offer(5, 0, 0, 0);
        #1;
        n_checks++; if (ifc.in_ready !== 1'b1 || rf_r0addr !== 5'd5) begin n_fail++; $display("FAIL read_issue: got ready=%0b r0addr=%0d want 1/5", ifc.in_ready, rf_r0addr); end
        step();
        ifc.in_valid = 0;
        n_checks++; if (ifc.out_valid !== 1'b1) begin n_fail++; $display("FAIL read_latency: got out_valid=%0b want 1", ifc.out_valid); end
        n_checks++; if (ifc.out_rs1val !== 32'h1234 || ifc.out_rs2val !== 32'd0) begin n_fail++; $display("FAIL read_values: got %h/%h want 1234/0", ifc.out_rs1val, ifc.out_rs2val); end
        n_checks++; if (ifc.out_uop !== m_uop) begin n_fail++; $display("FAIL read_uop: got %h want %h", ifc.out_uop, m_uop); end
        step();
        n_checks++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL read_drain: got out_valid=%0b want 0", ifc.out_valid); end
    endtask

    task automatic test_x0();
        wb_en = 1; wb_addr = 0; wb_val = 32'hFFFF;
        offer(0, 0, 0, 0);
        #1;
        n_checks++; if (rf_w0en !== 1'b0) begin n_fail++; $display("FAIL x0_write_en: got %0b want 0", rf_w0en); end
        step();
        n_checks++; if (ifc.out_rs1val !== 32'd0) begin n_fail++; $display("FAIL x0_bypass: got %h want 0", ifc.out_rs1val); end
        wb_en = 0;
        offer(0, 0, 0, 0);
        #1;
        n_checks++; if (rf_w0en !== 1'b0) begin n_fail++; $display("FAIL x0_write_idle: got %0b want 0", rf_w0en); end
        step();
        idle();
        n_checks++; if (ifc.out_valid !== 1'b1 || ifc.out_rs1val !== 32'd0) begin n_fail++; $display("FAIL x0_read: got v=%0b val=%h want 1/0", ifc.out_valid, ifc.out_rs1val); end
        step();
    endtask

    task automatic test_raw();
        offer(0, 0, 7, 1);
        step();
        offer(7, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (ifc.in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall[%0d]: got in_ready=%0b want 0", i, ifc.in_ready); end
            step();
        end
        wb_en = 1; wb_addr = 7; wb_val = 32'hAA;
        #1;
        n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release: got in_ready=%0b want 1", ifc.in_ready); end
        step();
        idle();
        n_checks++; if (ifc.out_valid !== 1'b1 || ifc.out_rs1val !== 32'hAA) begin n_fail++; $display("FAIL raw_bypass: got v=%0b val=%h want 1/aa", ifc.out_valid, ifc.out_rs1val); end
        step();
    endtask

    task automatic test_waw();
        offer(0, 0, 3, 1);
        step();
        offer(0, 0, 3, 1);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (ifc.in_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall[%0d]: got in_ready=%0b want 0", i, ifc.in_ready); end
            step();
        end
        wb_en = 1; wb_addr = 3; wb_val = 32'h33;
        #1;
        n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL waw_release: got in_ready=%0b want 1", ifc.in_ready); end
        step();
        wb_en = 0;
        offer(3, 0, 0, 0);
        #1;
        n_checks++; if (ifc.in_ready !== 1'b0) begin n_fail++; $display("FAIL waw_set_wins: got in_ready=%0b want 0", ifc.in_ready); end
        step();
        wb_en = 1; wb_addr = 3; wb_val = 32'h77;
        #1;
        n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL waw_second_clear: got in_ready=%0b want 1", ifc.in_ready); end
        step();
        idle();
        n_checks++; if (ifc.out_rs1val !== 32'h77) begin n_fail++; $display("FAIL waw_value: got %h want 77", ifc.out_rs1val); end
        step();
    endtask

    task automatic test_backpressure();
        offer(1, 2, 0, 0);
        step();
        ifc.out_ready = 0;
        offer(2, 1, 0, 0);
        wb_en = 1; wb_addr = 1;
        for (int i = 0; i < 4; i++) begin
            wb_val = $urandom;
            #1;
            n_checks++; if (ifc.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %0b want 0", i, ifc.in_ready); end
            step();
            n_checks++; if (ifc.out_valid !== 1'b1 || ifc.out_rs1val !== m_rs1v || ifc.out_rs2val !== m_rs2v || ifc.out_uop !== m_uop) begin
                n_fail++; $display("FAIL hold_stable[%0d]: got v=%0b %h/%h uop=%h want 1 %h/%h uop=%h", i, ifc.out_valid, ifc.out_rs1val, ifc.out_rs2val, ifc.out_uop, m_rs1v, m_rs2v, m_uop);
            end
        end
        wb_en = 0;
        ifc.out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            offer(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 0, 0);
            #1;
            n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %0b want 1", i, ifc.in_ready); end
            step();
            n_checks++; if (ifc.out_valid !== 1'b1 || ifc.out_uop !== m_uop || ifc.out_rs1val !== m_rs1v || ifc.out_rs2val !== m_rs2v) begin
                n_fail++; $display("FAIL stream_out[%0d]: got v=%0b uop=%h %h/%h want 1 uop=%h %h/%h", i, ifc.out_valid, ifc.out_uop, ifc.out_rs1val, ifc.out_rs2val, m_uop, m_rs1v, m_rs2v);
            end
        end
        idle();
        step();
    endtask

    task automatic test_reset_mid();
        offer(0, 0, 9, 1);
        step();
        idle();
        ifc.out_ready = 0;
        #1;
        rst = 0;
        model_reset();
        #1;
        n_checks++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %0b want 0", ifc.out_valid); end
        n_checks++; if (rf_w0en !== 1'b0) begin n_fail++; $display("FAIL midrst_rf_write: got %0b want 0", rf_w0en); end
        step();
        rst = 1;
        ifc.out_ready = 1;
        offer(9, 0, 0, 0);
        #1;
        n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_accept: got in_ready=%0b want 1", ifc.in_ready); end
        step();
        idle();
        n_checks++; if (ifc.out_valid !== 1'b1 || ifc.out_rs1val !== m_regs[9]) begin n_fail++; $display("FAIL midrst_value: got v=%0b val=%h want 1 %h", ifc.out_valid, ifc.out_rs1val, m_regs[9]); end
        step();
    endtask

    task automatic test_random();
        int q[$];
        for (int c = 0; c < 400; c++) begin
            ifc.in_valid  = ($urandom_range(0, 9) < 7);
            ifc.in_rs1    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 8));
            ifc.in_rs2    = 5'($urandom_range(0, 8));
            ifc.in_rd     = 5'($urandom_range(0, 8));
            ifc.in_rd_en  = $urandom_range(0, 1);
            ifc.in_uop    = {$urandom, $urandom};
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            wb_en  = ($urandom_range(0, 9) < 4);
            wb_val = $urandom;
            q.delete();
            for (int i = 1; i < 32; i++) if (m_busy[i]) q.push_back(i);
            wb_addr = (q.size() > 0 && $urandom_range(0, 3) != 0) ? 5'(q[$urandom_range(0, q.size() - 1)])
                                                                  : 5'($urandom_range(0, 31));
            #1;
            n_checks++; if (ifc.in_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_in_ready[%0d]: got %0b want %0b", c, ifc.in_ready, m_ready()); end
            n_checks++; if (rf_w0en !== (wb_en && wb_addr != 5'd0) || rf_w0addr !== wb_addr || rf_w0val !== wb_val) begin
                n_fail++; $display("FAIL rnd_wport[%0d]: got %0b/%0d/%h for wb %0b/%0d/%h", c, rf_w0en, rf_w0addr, rf_w0val, wb_en, wb_addr, wb_val);
            end
            step();
            n_checks++; if (ifc.out_valid !== m_ov) begin n_fail++; $display("FAIL rnd_out_valid[%0d]: got %0b want %0b", c, ifc.out_valid, m_ov); end
            if (m_ov) begin
                n_checks++; if (ifc.out_rs1val !== m_rs1v || ifc.out_rs2val !== m_rs2v || ifc.out_rd !== m_rd || ifc.out_rd_en !== m_rd_en || ifc.out_uop !== m_uop) begin
                    n_fail++; $display("FAIL rnd_out[%0d]: got %h/%h rd=%0d en=%0b uop=%h want %h/%h rd=%0d en=%0b uop=%h", c, ifc.out_rs1val, ifc.out_rs2val, ifc.out_rd, ifc.out_rd_en, ifc.out_uop, m_rs1v, m_rs2v, m_rd, m_rd_en, m_uop);
                end
            end
        end
        idle();
        step();
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 32; i++) begin
            v = $urandom;
            rf_mem[i] = v;
            m_regs[i] = v;
        end
        test_reset();
        test_wb_then_read();
        test_x0();
        test_raw();
        test_waw();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Register-read stage of the core pipeline, sitting between decode and execute: the initiator side of the register file's two read ports and one write port. It accepts one decoded uop per cycle, drives the register file read addresses, forwards same-cycle writeback data, and tracks pending destination writes in a 32-entry scoreboard to stall on RAW/WAW hazards. It also owns the register file write port, suppressing writes to x0. Resolved operands go to execute through a registered valid/ready output stage.

## Interface
- XLEN, 32, data width of uop_val_t
- UOPW, 64, width of the opaque uop payload passed through unchanged

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  decode offers a uop
- in_ready  out  1  stage accepts the uop this cycle (combinational)
- in_rs1, in_rs2  in  5 each  source register indices (uop_reg_t)
- in_rd  in  5  destination register index
- in_rd_en  in  1  uop writes in_rd
- in_uop  in  UOPW  payload
- rf_r0addr, rf_r1addr  out  5 each  register file read addresses (= in_rs1, in_rs2, combinational)
- rf_r0val, rf_r1val  in  XLEN each  combinational read data
- rf_w0en, rf_w0addr, rf_w0val  out  1/5/XLEN  register file write port
- wb_en, wb_addr, wb_val  in  1/5/XLEN  writeback from the retiring uop
- out_valid  out  1  operands ready for execute
- out_ready  in  1  execute accepts
- out_rs1val, out_rs2val  out  XLEN each  resolved operands
- out_rd, out_rd_en, out_uop  out  5/1/UOPW  passed through

## Operation
- Write port: rf_w0en = wb_en && wb_addr != 0; rf_w0addr = wb_addr; rf_w0val = wb_val; combinational.
- Operand resolve per source rsN: if rsN == 0 -> 0; else if wb_en && wb_addr == rsN -> wb_val (bypass, register file write not visible until next edge); else rf value.
- Scoreboard busy[31:1], busy[0] constant 0.
- Hazard: src_stall = busy[rs1] or busy[rs2] after masking entries cleared by this cycle's writeback; dst_stall = in_rd_en && busy[in_rd] after the same masking. Sources checked regardless of uop usage.
- Output stage free: !out_valid || out_ready.
- in_ready = free && !src_stall && !dst_stall. Accept = in_valid && in_ready.
- On accept: output registers load resolved operands, in_rd, in_rd_en, in_uop; out_valid <= 1.
- Else if out_ready: out_valid <= 0.
- Scoreboard update per edge: clear busy[wb_addr] on wb_en; set busy[in_rd] on accept with in_rd_en && in_rd != 0; set wins on same index.
- Held output (out_valid && !out_ready): payload and operands stable, no re-read.
- wb_en to a non-busy register: legal, no scoreboard effect besides clear.

## Timing
- Reset (rst low, async): out_valid=0, busy all 0, output data registers 0; in_ready may be 1 immediately after reset release.
- Latency: accept at edge T -> out_valid high after T, data valid same cycle.
- Throughput: 1 uop/cycle while out_ready=1 and no hazards.
- Dependent back-to-back uops: consumer stalls until its producer's wb_en cycle, issued in that cycle via bypass (zero extra bubble after writeback).
- Reset mid-operation: in-flight output and scoreboard discarded; no rf write occurs while wb_en low.

## Test plan
- Reset, write x5=0x1234 via wb, then uop rs1=5 rs2=0 -> out_rs1val=0x1234, out_rs2val=0, out_valid one cycle after accept.
- wb x0=0xFFFF then uop rs1=0 -> rf_w0en=0 throughout, out_rs1val=0.
- uop A rd=7 accepted, uop B rs1=7 offered -> in_ready=0 until wb_en,wb_addr=7,wb_val=0xAA; B accepted that cycle with out_rs1val=0xAA.
- uop rd=3 accepted, next uop rd=3 (WAW) -> stall until wb x3; same cycle set/clear leaves busy[3]=1.
- out_ready held 0 for 4 cycles with valid output -> out_* stable, in_ready=0, then drains and 1/cycle resumes.
- Assert rst low with out_valid=1 and busy[9]=1 -> out_valid=0 and rs1=9 uop accepted immediately after release.
